// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed ASCII LED command parser between UART_RX and UART_TX
// Optional '?' status query frame is compiled in when CMD_QUERY_EN is defined.
module uart_cmd_parser #(
  parameter int CLKS_PER_TIMEOUT = 2500000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_TX_Done,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic       o_LED_R_n,
  output logic       o_LED_G_n,
  output logic       o_LED_B_n,
  output logic       o_Overrun,
  output logic       o_Busy
);

  localparam int TW = $clog2(CLKS_PER_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(CLKS_PER_TIMEOUT - 1);

  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_G    = 8'h47;
  localparam logic [7:0] CH_B    = 8'h42;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_1    = 8'h31;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_OK   = 8'h4B;
  localparam logic [7:0] CH_ERR  = 8'h45;
  localparam logic [7:0] CH_QRY  = 8'h3F;

  typedef enum logic [2:0] {S_IDLE, S_ARG, S_TERM, S_SKIP, S_RESP} state_t;
  typedef enum logic [1:0] {SEL_R, SEL_G, SEL_B, SEL_Q} sel_t;

  state_t     state, state_n;
  sel_t       sel, rx_sel;
  logic       value;
  logic       led_r, led_g, led_b;
  logic [TW-1:0] tmo_cnt;
  logic [1:0] resp_idx;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       overrun;

  logic       is_term, is_digit, is_letter, is_query;
  logic       load_resp, led_we, tmo_run, tmo_expired;
  logic [7:0] resp_char;

  assign is_term   = (i_RX_Byte == CH_CR) || (i_RX_Byte == CH_LF);
  assign is_digit  = (i_RX_Byte == CH_0)  || (i_RX_Byte == CH_1);
  assign is_letter = (i_RX_Byte == CH_R)  || (i_RX_Byte == CH_G) || (i_RX_Byte == CH_B);
`ifdef CMD_QUERY_EN
  assign is_query  = (i_RX_Byte == CH_QRY);
`else
  assign is_query  = 1'b0;
`endif

  always_comb begin
    rx_sel = SEL_R;
    case (i_RX_Byte)
      CH_G:    rx_sel = SEL_G;
      CH_B:    rx_sel = SEL_B;
      CH_QRY:  rx_sel = SEL_Q;
      default: rx_sel = SEL_R;
    endcase
  end

  assign tmo_expired = tmo_run && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_n   = state;
    load_resp = 1'b0;
    resp_char = CH_OK;
    led_we    = 1'b0;
    tmo_run   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_RX_DV) begin
          if (is_letter)      state_n = S_ARG;
          else if (is_query)  state_n = S_TERM;
          else if (!is_term)  state_n = S_SKIP;
        end
      end
      S_ARG: begin
        tmo_run = 1'b1;
        if (i_RX_DV) begin
          if (is_digit) begin
            state_n = S_TERM;
          end else if (is_term) begin
            load_resp = 1'b1;
            resp_char = CH_ERR;
          end else begin
            state_n = S_SKIP;
          end
        end else if (tmo_expired) begin
          state_n = S_IDLE;
        end
      end
      S_TERM: begin
        tmo_run = 1'b1;
        if (i_RX_DV) begin
          if (is_term) begin
            load_resp = 1'b1;
            if (sel == SEL_Q) begin
              resp_char = CH_0 | {5'b0, led_b, led_g, led_r};
            end else begin
              led_we    = 1'b1;
              resp_char = CH_OK;
            end
          end else begin
            state_n = S_SKIP;
          end
        end else if (tmo_expired) begin
          state_n = S_IDLE;
        end
      end
      S_SKIP: begin
        tmo_run = 1'b1;
        if (i_RX_DV) begin
          if (is_term) begin
            load_resp = 1'b1;
            resp_char = CH_ERR;
          end
        end else if (tmo_expired) begin
          state_n = S_IDLE;
        end
      end
      S_RESP: begin
        if (i_TX_Done && (resp_idx == 2'd2)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (load_resp) state_n = S_RESP;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= S_IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sel      <= SEL_R;
      value    <= 1'b0;
      led_r    <= 1'b0;
      led_g    <= 1'b0;
      led_b    <= 1'b0;
      tmo_cnt  <= '0;
      resp_idx <= 2'd0;
      tx_dv    <= 1'b0;
      tx_byte  <= 8'h00;
      overrun  <= 1'b0;
    end else begin
      if (state == S_IDLE && i_RX_DV) sel <= rx_sel;
      if (state == S_ARG && i_RX_DV && is_digit) value <= i_RX_Byte[0];

      if (led_we) begin
        case (sel)
          SEL_R:   led_r <= value;
          SEL_G:   led_g <= value;
          SEL_B:   led_b <= value;
          default: ;
        endcase
      end

      // A byte arriving on the expiry cycle clears the counter and is processed normally.
      if (!tmo_run || i_RX_DV || tmo_expired) tmo_cnt <= '0;
      else                                    tmo_cnt <= tmo_cnt + TW'(1);

      if (state == S_RESP && i_RX_DV) overrun <= 1'b1;

      tx_dv <= 1'b0;
      if (load_resp) begin
        tx_dv    <= 1'b1;
        tx_byte  <= resp_char;
        resp_idx <= 2'd0;
      end else if (state == S_RESP && i_TX_Done && resp_idx != 2'd2) begin
        tx_dv    <= 1'b1;
        tx_byte  <= (resp_idx == 2'd0) ? CH_CR : CH_LF;
        resp_idx <= resp_idx + 2'd1;
      end
    end
  end

  assign o_TX_DV   = tx_dv;
  assign o_TX_Byte = tx_byte;
  assign o_LED_R_n = ~led_r;
  assign o_LED_G_n = ~led_g;
  assign o_LED_B_n = ~led_b;
  assign o_Overrun = overrun;
  assign o_Busy    = (state == S_RESP);

endmodule
